nark_fwd_backend: RTL and testbench

Parametrised Execute/Memory/Writeback backend for the NARK pipelined core, with an integrated register file. It accepts decoded instructions from the decode stage and runs them through three pipeline registers (ID/EX, EX/MEM, MEM/WB), each carrying a valid bit. It adds EX/MEM and MEM/WB operand forwarding, load-use stall detection, flush-to-bubble, and a write-through register file.

---
 rtl/nark_fwd_backend.sv | 179 +++++++++++++++++
 tb/tb_nark_fwd_backend.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nark_fwd_backend.sv
// NARK core backend: ID/EX, EX/MEM, MEM/WB pipeline registers with a write-through
// register file, EX/MEM and MEM/WB operand forwarding, load-use stall and flush.
module nark_fwd_backend #(
   parameter int BITS    = 24,
   parameter int RA_BITS = 4
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               IssueValid,
   input  logic [RA_BITS-1:0] RA1,
   input  logic [RA_BITS-1:0] RA2,
   input  logic [RA_BITS-1:0] WA,
   input  logic [BITS-1:0]    ExtImm,
   input  logic               ALUSrc,
   input  logic [1:0]         ALUControl,
   input  logic               MemWrite,
   input  logic               MentoReg,
   input  logic               RegWrite,
   input  logic               Flush,
   output logic               Stall,
   output logic [3:0]         ALUFlags,
   output logic               FlagsValid,
   output logic [BITS-1:0]    MemAddr,
   output logic [BITS-1:0]    MemWData,
   output logic               MemWE,
   input  logic [BITS-1:0]    MemRData,
   output logic               WbValid,
   output logic [RA_BITS-1:0] WbAddr,
   output logic [BITS-1:0]    WbData
);

   localparam int DEPTH  = 2**RA_BITS;
   localparam int STAGES = 3;
   localparam int MSB    = BITS-1;

   typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR} alu_op_t;

   typedef struct packed {
      logic [RA_BITS-1:0] ra1;
      logic [RA_BITS-1:0] ra2;
      logic [RA_BITS-1:0] wa;
      logic [BITS-1:0]    rd1;
      logic [BITS-1:0]    rd2;
      logic [BITS-1:0]    imm;
      logic               alusrc;
      alu_op_t            op;
      logic               mw;
      logic               ld;
      logic               rw;
   } idex_t;

   typedef struct packed {
      logic [BITS-1:0]    alu;
      logic [BITS-1:0]    wd;
      logic [RA_BITS-1:0] wa;
      logic               rw;
      logic               ld;
      logic               mw;
   } exmem_t;

   typedef struct packed {
      logic [BITS-1:0]    data;
      logic [RA_BITS-1:0] wa;
      logic               rw;
   } memwb_t;

   // vld_pipe[1] = ID/EX, [2] = EX/MEM, [3] = MEM/WB
   logic [STAGES:1] vld_pipe;
   idex_t           ex;
   exmem_t          mem;
   memwb_t          wb;
   logic [BITS-1:0] rf [DEPTH];

   logic            issue_ok;
   logic [BITS-1:0] rd1, rd2;
   logic            fwd_m;
   logic [BITS-1:0] src_a, src_d, opb;
   logic [BITS-1:0] res;
   logic [BITS:0]   sum;
   logic            c_f, v_f;

   assign WbValid  = vld_pipe[3] & wb.rw;
   assign WbAddr   = wb.wa;
   assign WbData   = wb.data;
   assign MemAddr  = mem.alu;
   assign MemWData = mem.wd;
   assign MemWE    = vld_pipe[2] & mem.mw;
   assign FlagsValid = vld_pipe[1];

   // write-through: the value retiring this cycle is visible to the reader
   assign rd1 = (WbValid && WbAddr == RA1) ? WbData : rf[RA1];
   assign rd2 = (WbValid && WbAddr == RA2) ? WbData : rf[RA2];

   // only a load in EX can't be forwarded in time; flush masks the hazard
   assign Stall = IssueValid & ~Flush & vld_pipe[1] & ex.ld & ex.rw &
                  ((ex.wa == RA1) | ((ex.wa == RA2) & (~ALUSrc | MemWrite)));
   assign issue_ok = IssueValid & ~Stall & ~Flush;

   assign fwd_m = vld_pipe[2] & mem.rw & ~mem.ld;

   always_comb begin
      src_a = ex.rd1;
      if (fwd_m && mem.wa == ex.ra1)        src_a = mem.alu;
      else if (WbValid && WbAddr == ex.ra1) src_a = WbData;
      src_d = ex.rd2;
      if (fwd_m && mem.wa == ex.ra2)        src_d = mem.alu;
      else if (WbValid && WbAddr == ex.ra2) src_d = WbData;
      opb = ex.alusrc ? ex.imm : src_d;
   end

   always_comb begin
      sum = '0;
      res = '0;
      c_f = 1'b0;
      v_f = 1'b0;
      unique case (ex.op)
         ALU_ADD: begin
            sum = {1'b0, src_a} + {1'b0, opb};
            res = sum[MSB:0];
            c_f = sum[BITS];
            v_f = (src_a[MSB] == opb[MSB]) && (res[MSB] != src_a[MSB]);
         end
         ALU_SUB: begin
            // carry out of A + ~B + 1 is the unsigned no-borrow flag
            sum = {1'b0, src_a} + {1'b0, ~opb} + {{BITS{1'b0}}, 1'b1};
            res = sum[MSB:0];
            c_f = sum[BITS];
            v_f = (src_a[MSB] != opb[MSB]) && (res[MSB] != src_a[MSB]);
         end
         ALU_AND: res = src_a & opb;
         ALU_ORR: res = src_a | opb;
         default: res = '0;
      endcase
   end

   assign ALUFlags = vld_pipe[1] ? {res[MSB], (res == '0), c_f, v_f} : 4'b0000;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         vld_pipe <= '0;
         ex       <= '0;
         mem      <= '0;
         wb       <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:1], issue_ok};
         if (issue_ok) begin
            ex.ra1    <= RA1;
            ex.ra2    <= RA2;
            ex.wa     <= WA;
            ex.rd1    <= rd1;
            ex.rd2    <= rd2;
            ex.imm    <= ExtImm;
            ex.alusrc <= ALUSrc;
            ex.op     <= alu_op_t'(ALUControl);
            ex.mw     <= MemWrite;
            ex.ld     <= MentoReg;
            ex.rw     <= RegWrite;
         end
         mem.alu <= res;
         mem.wd  <= src_d;
         mem.wa  <= ex.wa;
         mem.rw  <= ex.rw;
         mem.ld  <= ex.ld;
         mem.mw  <= ex.mw;
         wb.data <= mem.ld ? MemRData : mem.alu;
         wb.wa   <= mem.wa;
         wb.rw   <= mem.rw;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
      end else if (WbValid) begin
         rf[WbAddr] <= WbData;
      end
   end

endmodule

// File: tb/tb_nark_fwd_backend.sv
// Bench for nark_fwd_backend: directed scenarios plus random instruction stream,
// checked against an in-order instruction-level model with fixed stage latencies.
module tb_nark_fwd_backend;

   logic        CLK = 1'b0;
   logic        RST;
   logic        IssueValid;
   logic [3:0]  RA1, RA2, WA;
   logic [23:0] ExtImm;
   logic        ALUSrc;
   logic [1:0]  ALUControl;
   logic        MemWrite, MentoReg, RegWrite, Flush;
   logic        Stall;
   logic [3:0]  ALUFlags;
   logic        FlagsValid;
   logic [23:0] MemAddr, MemWData;
   logic        MemWE;
   logic [23:0] MemRData;
   logic        WbValid;
   logic [3:0]  WbAddr;
   logic [23:0] WbData;

   nark_fwd_backend #(.BITS(24), .RA_BITS(4)) dut (
      .CLK(CLK), .RST(RST), .IssueValid(IssueValid), .RA1(RA1), .RA2(RA2), .WA(WA),
      .ExtImm(ExtImm), .ALUSrc(ALUSrc), .ALUControl(ALUControl), .MemWrite(MemWrite),
      .MentoReg(MentoReg), .RegWrite(RegWrite), .Flush(Flush), .Stall(Stall),
      .ALUFlags(ALUFlags), .FlagsValid(FlagsValid), .MemAddr(MemAddr),
      .MemWData(MemWData), .MemWE(MemWE), .MemRData(MemRData), .WbValid(WbValid),
      .WbAddr(WbAddr), .WbData(WbData)
   );

   always #5 CLK = ~CLK;

   function automatic logic [23:0] memfn(input logic [23:0] a);
      return (a * 24'd7) ^ 24'h00ABCD;
   endfunction

   assign MemRData = memfn(MemAddr);

   // one retired instruction as seen at the pins
   typedef struct packed {
      logic        v, rw, ld, st;
      logic [3:0]  wa, fl;
      logic [23:0] res, wd, wbd;
   } exp_t;

   logic [23:0] mregs [16];
   exp_t pe, pm, pw;
   int   vectors = 0, miscompares = 0;
   logic last_stall;
   int   last_stalls;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      pe = '0; pm = '0; pw = '0;
      for (int i = 0; i < 16; i++) mregs[i] = '0;
   endtask

   // sequential-ISA execution of the instruction currently on the issue pins
   task automatic exec(output exp_t e);
      logic [23:0] a, d, b, r;
      longint ua, ub, sa, sb, s, sv;
      logic c, v;
      a = mregs[RA1]; d = mregs[RA2]; b = ALUSrc ? ExtImm : d;
      ua = longint'(a); ub = longint'(b);
      sa = a[23] ? ua - 64'sd16777216 : ua;
      sb = b[23] ? ub - 64'sd16777216 : ub;
      c = 1'b0; v = 1'b0; s = 0;
      case (ALUControl)
         2'd0: begin s = ua + ub; c = (s > 16777215); sv = sa + sb;
                     v = (sv > 8388607) || (sv < -8388608); r = s[23:0]; end
         2'd1: begin s = ua - ub; c = (ua >= ub); sv = sa - sb;
                     v = (sv > 8388607) || (sv < -8388608); r = s[23:0]; end
         2'd2: r = a & b;
         default: r = a | b;
      endcase
      e = '0;
      e.v = 1'b1; e.rw = RegWrite; e.ld = MentoReg; e.st = MemWrite; e.wa = WA;
      e.res = r; e.wd = d; e.fl = {r[23], (r == 24'd0), c, v};
      e.wbd = MentoReg ? memfn(r) : r;
      if (RegWrite) mregs[WA] = e.wbd;
   endtask

   // check the pins mid-cycle, then advance one clock
   task automatic cyc();
      logic es, acc;
      exp_t n;
      @(negedge CLK);
      es = IssueValid & ~Flush & pe.v & pe.ld & pe.rw &
           ((pe.wa == RA1) | ((pe.wa == RA2) & (~ALUSrc | MemWrite)));
      chk("stall", 32'(Stall), 32'(es));
      chk("flags_valid", 32'(FlagsValid), 32'(pe.v));
      if (pe.v) chk("alu_flags", 32'(ALUFlags), 32'(pe.fl));
      chk("mem_we", 32'(MemWE), 32'(pm.v & pm.st));
      if (pm.v && pm.st) begin
         chk("mem_addr", 32'(MemAddr), 32'(pm.res));
         chk("mem_wdata", 32'(MemWData), 32'(pm.wd));
      end
      chk("wb_valid", 32'(WbValid), 32'(pw.v & pw.rw));
      if (pw.v && pw.rw) begin
         chk("wb_addr", 32'(WbAddr), 32'(pw.wa));
         chk("wb_data", 32'(WbData), 32'(pw.wbd));
      end
      acc = IssueValid & ~Flush & ~es;
      n = '0;
      if (acc) exec(n);
      last_stall = es;
      @(posedge CLK);
      pw = pm; pm = pe; pe = n;
      #1;
   endtask

   task automatic put(input logic iv, input logic [3:0] a1, a2, w, input logic [23:0] imm,
                      input logic src, input logic [1:0] ctl, input logic mw, ld, rw, fl);
      IssueValid = iv; RA1 = a1; RA2 = a2; WA = w; ExtImm = imm; ALUSrc = src;
      ALUControl = ctl; MemWrite = mw; MentoReg = ld; RegWrite = rw; Flush = fl;
   endtask

   // present an instruction and hold it until accepted (bounded)
   task automatic issue(input logic [3:0] a1, a2, w, input logic [23:0] imm, input logic src,
                        input logic [1:0] ctl, input logic mw, ld, rw, fl);
      int n;
      put(1'b1, a1, a2, w, imm, src, ctl, mw, ld, rw, fl);
      n = 0;
      do begin cyc(); n++; end while (last_stall && n < 4);
      last_stalls = n - 1;
      chk("stall_release", 32'(last_stall), 32'd0);
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) begin
         put(1'b0, 4'd0, 4'd0, 4'd0, 24'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
         cyc();
      end
   endtask

   initial begin
      RST = 1'b0;
      put(1'b0, 4'd0, 4'd0, 4'd0, 24'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      model_reset();
      last_stall = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_stall", 32'(Stall), 32'd0);
      chk("rst_mem_we", 32'(MemWE), 32'd0);
      chk("rst_wb_valid", 32'(WbValid), 32'd0);
      chk("rst_flags_valid", 32'(FlagsValid), 32'd0);
      chk("rst_alu_flags", 32'(ALUFlags), 32'd0);
      chk("rst_mem_addr", 32'(MemAddr), 32'd0);
      chk("rst_mem_wdata", 32'(MemWData), 32'd0);
      chk("rst_wb_addr", 32'(WbAddr), 32'd0);
      chk("rst_wb_data", 32'(WbData), 32'd0);
      RST = 1'b1;

      // R1 = R0+5 ; R2 = R1+R1 back to back
      issue(4'd0, 4'd0, 4'd1, 24'd5, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      issue(4'd1, 4'd1, 4'd2, 24'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("fwd_no_stall", 32'(last_stalls), 32'd0);
      idle(1);
      chk("r1_wb", {4'(WbAddr), 24'(WbData)}, {4'd1, 24'd5});
      idle(1);
      chk("r2_wb", {4'(WbAddr), 24'(WbData)}, {4'd2, 24'd10});

      // LDR R3 ; R4 = R3+1 costs one stall
      issue(4'd0, 4'd0, 4'd3, 24'd0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      issue(4'd3, 4'd0, 4'd4, 24'd1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("load_use_stalls", 32'(last_stalls), 32'd1);
      idle(2);
      chk("r4_wb", {4'(WbAddr), 24'(WbData)}, {4'd4, 24'h00ABCE});

      // 1 - 2 and 0x7FFFFF + 1 flags
      issue(4'd0, 4'd0, 4'd5, 24'd1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      issue(4'd0, 4'd0, 4'd6, 24'd2, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      issue(4'd5, 4'd6, 4'd7, 24'd0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("sub_flags", 32'(ALUFlags), 32'b1000);
      idle(1);
      chk("sub_result", 32'(MemAddr), 32'h00FFFFFF);
      issue(4'd0, 4'd0, 4'd8, 24'h7FFFFF, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      issue(4'd8, 4'd0, 4'd9, 24'd1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("add_ovf_flags", 32'(ALUFlags), 32'b1001);
      idle(3);

      // flushed store while R1 retires, then the same store unflushed
      issue(4'd0, 4'd0, 4'd1, 24'h000123, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(2);
      issue(4'd0, 4'd1, 4'd0, 24'h40, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      idle(1);
      chk("flushed_store_we", 32'(MemWE), 32'd0);
      idle(2);
      issue(4'd0, 4'd0, 4'd1, 24'h000456, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(2);
      issue(4'd0, 4'd1, 4'd0, 24'h40, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(1);
      chk("store_we", 32'(MemWE), 32'd1);
      chk("store_wdata", 32'(MemWData), 32'h000456);
      idle(2);

      // flush coinciding with a load-use hazard
      issue(4'd0, 4'd0, 4'd3, 24'd4, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      put(1'b1, 4'd3, 4'd0, 4'd4, 24'd1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      #1;
      chk("flush_over_stall", 32'(Stall), 32'd0);
      cyc();
      chk("flush_bubble", 32'(FlagsValid), 32'd0);
      idle(3);

      // reset with three instructions in flight
      issue(4'd0, 4'd0, 4'd10, 24'd3, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      issue(4'd10, 4'd10, 4'd0, 24'd8, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      issue(4'd10, 4'd0, 4'd12, 24'd1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("inflight_we", 32'(MemWE), 32'd1);
      IssueValid = 1'b0;
      #2 RST = 1'b0;
      #1;
      chk("midrst_wb_valid", 32'(WbValid), 32'd0);
      chk("midrst_mem_we", 32'(MemWE), 32'd0);
      chk("midrst_flags_valid", 32'(FlagsValid), 32'd0);
      model_reset();
      last_stall = 1'b0;
      @(posedge CLK);
      #1 RST = 1'b1;
      idle(3);
      for (int k = 0; k < 16; k++)
         issue(4'(k), 4'd0, 4'(k), 24'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(3);

      // random stream; decode holds its inputs while stalled
      for (int i = 0; i < 500; i++) begin
         if (!last_stall) begin
            logic ld, mw;
            logic [23:0] imm;
            ld = ($urandom_range(0, 3) == 0);
            mw = !ld && ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 5))
               0: imm = 24'h7FFFFF;
               1: imm = 24'hFFFFFF;
               2: imm = 24'h800000;
               default: imm = 24'($urandom);
            endcase
            put($urandom_range(0, 9) < 8, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                4'($urandom_range(0, 7)), imm, 1'($urandom), 2'($urandom), mw, ld,
                $urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0);
         end
         cyc();
      end
      idle(4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
